// File: rtl/sbus_mem_ctl.sv
// rtl/sbus_mem_ctl.sv - SBUS memory-side responder over a 1-cycle-latency single-port RAM.
// Optional write-strobe timeout: define SBUS_MEM_WR_TIMEOUT_EN.
module sbus_mem_ctl #(
    parameter int AW         = 22,
    parameter int WR_TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          CROBAR_N,
    input  logic          SBUS_MEM_RESET,
    input  logic          SBUS_START_A,
    input  logic          SBUS_START_B,
    input  logic [3:0]    SBUS_RQ,
    input  logic          SBUS_RD_RQ,
    input  logic          SBUS_WR_RQ,
    input  logic [AW-1:0] SBUS_ADR,
    input  logic          SBUS_ADR_PAR,
    input  logic [35:0]   SBUS_D_IN,
    input  logic          SBUS_DATA_PAR_IN,
    input  logic          SBUS_DATA_VALID_A_IN,
    input  logic          SBUS_DATA_VALID_B_IN,
    output logic          SBUS_ACKN_A,
    output logic          SBUS_ACKN_B,
    output logic          SBUS_DATA_VALID_A_OUT,
    output logic          SBUS_DATA_VALID_B_OUT,
    output logic [35:0]   SBUS_D_OUT,
    output logic          SBUS_DATA_PAR_OUT,
    output logic          SBUS_ERROR,
    output logic          SBUS_ADR_PAR_ERR,
    output logic [AW-1:0] RAM_ADR,
    output logic          RAM_WE,
    output logic [36:0]   RAM_WDATA,
    input  logic [36:0]   RAM_RDATA
);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_RD, S_WR, S_DRAIN} state_t;

    // First set mask bit at or after position s, wrapping mod 4.
    function automatic logic [1:0] next_pos(input logic [3:0] m, input logic [1:0] s);
        logic [1:0] p;
        next_pos = s;
        for (int i = 3; i >= 0; i--) begin
            p = s + 2'(i);
            if (m[p]) next_pos = p;
        end
    endfunction

    state_t        state_q;
    logic          port_b_q, ok_q, rd_q, inflight_q, arm_a_q, arm_b_q;
    logic [AW-3:0] base_q;
    logic [1:0]    pos_q;
    logic [3:0]    mask_q;
    logic          ack_a_q, ack_b_q, dv_a_q, dv_b_q, err_q, par_err_q, ram_we_q;
    logic [35:0]   dout_q;
    logic          dpar_q;
    logic [AW-1:0] ram_adr_q;
    logic [36:0]   ram_wdata_q;
`ifdef SBUS_MEM_WR_TIMEOUT_EN
    localparam int TW = $clog2(WR_TIMEOUT) + 1;
    logic [TW-1:0] tmo_q;
`endif

    logic        take_a, take_b, adr_par_ok, wr_stb;
    logic [1:0]  first_pos, pos_d;
    logic [3:0]  mask_d;
    logic [36:0] wr_word;

    assign take_a     = SBUS_START_A & arm_a_q;
    assign take_b     = SBUS_START_B & arm_b_q & ~take_a;
    assign adr_par_ok = ^{SBUS_ADR, SBUS_ADR_PAR};
    assign first_pos  = next_pos(SBUS_RQ, SBUS_ADR[1:0]);
    assign mask_d     = mask_q & ~(4'b0001 << pos_q);
    assign pos_d      = next_pos(mask_d, pos_q + 2'd1);
    assign wr_stb     = port_b_q ? SBUS_DATA_VALID_B_IN : SBUS_DATA_VALID_A_IN;
    assign wr_word    = {SBUS_DATA_PAR_IN, SBUS_D_IN};

    always_ff @(posedge CLK or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q     <= S_IDLE;
            port_b_q    <= 1'b0;
            ok_q        <= 1'b0;
            rd_q        <= 1'b0;
            inflight_q  <= 1'b0;
            arm_a_q     <= 1'b1;
            arm_b_q     <= 1'b1;
            base_q      <= '0;
            pos_q       <= 2'd0;
            mask_q      <= 4'd0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            dv_a_q      <= 1'b0;
            dv_b_q      <= 1'b0;
            err_q       <= 1'b0;
            par_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            dout_q      <= 36'd0;
            dpar_q      <= 1'b0;
            ram_adr_q   <= '0;
            ram_wdata_q <= 37'd0;
`ifdef SBUS_MEM_WR_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            dv_a_q     <= 1'b0;
            dv_b_q     <= 1'b0;
            err_q      <= 1'b0;
            par_err_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            inflight_q <= 1'b0;
            arm_a_q    <= arm_a_q | ~SBUS_START_A;
            arm_b_q    <= arm_b_q | ~SBUS_START_B;

            // RAM_RDATA now holds the word whose address the RAM sampled last edge.
            if (inflight_q && !SBUS_MEM_RESET) begin
                dv_a_q <= ~port_b_q;
                dv_b_q <= port_b_q;
                dout_q <= RAM_RDATA[35:0];
                dpar_q <= RAM_RDATA[36];
                err_q  <= ~^RAM_RDATA;
            end

            case (state_q)
                S_IDLE: begin
                    if (take_a || take_b) begin
                        port_b_q  <= take_b;
                        ack_a_q   <= take_a;
                        ack_b_q   <= take_b;
                        if (take_a) arm_a_q <= 1'b0;
                        if (take_b) arm_b_q <= 1'b0;
                        base_q    <= SBUS_ADR[AW-1:2];
                        mask_q    <= SBUS_RQ;
                        pos_q     <= first_pos;
                        ram_adr_q <= {SBUS_ADR[AW-1:2], first_pos};
                        rd_q      <= SBUS_RD_RQ;
                        par_err_q <= ~adr_par_ok;
                        err_q     <= ~adr_par_ok | (SBUS_RD_RQ == SBUS_WR_RQ);
                        ok_q      <= adr_par_ok & (SBUS_RD_RQ != SBUS_WR_RQ) & (|SBUS_RQ);
                        state_q   <= S_ACK;
                    end
                end
                S_ACK, S_RD: begin
                    if (state_q == S_ACK && !ok_q) begin
                        state_q <= S_IDLE;
                    end else if (state_q == S_ACK && !rd_q) begin
`ifdef SBUS_MEM_WR_TIMEOUT_EN
                        tmo_q <= TW'(WR_TIMEOUT - 2);
`endif
                        state_q <= S_WR;
                    end else begin
                        inflight_q <= 1'b1;
                        mask_q     <= mask_d;
                        pos_q      <= pos_d;
                        ram_adr_q  <= {base_q, pos_d};
                        state_q    <= (mask_d == 4'd0) ? S_DRAIN : S_RD;
                    end
                end
                S_DRAIN: state_q <= inflight_q ? S_DRAIN : S_IDLE;
                S_WR: begin
                    if (wr_stb) begin
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= wr_word;
                        ram_adr_q   <= {base_q, pos_q};
                        err_q       <= ~^wr_word;
                        mask_q      <= mask_d;
                        pos_q       <= pos_d;
`ifdef SBUS_MEM_WR_TIMEOUT_EN
                        tmo_q       <= TW'(WR_TIMEOUT - 1);
`endif
                        if (mask_d == 4'd0) state_q <= S_IDLE;
                    end
`ifdef SBUS_MEM_WR_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase

            if (SBUS_MEM_RESET) begin
                state_q    <= S_IDLE;
                inflight_q <= 1'b0;
                ack_a_q    <= 1'b0;
                ack_b_q    <= 1'b0;
                dv_a_q     <= 1'b0;
                dv_b_q     <= 1'b0;
                err_q      <= 1'b0;
                par_err_q  <= 1'b0;
                ram_we_q   <= 1'b0;
                arm_a_q    <= 1'b0;
                arm_b_q    <= 1'b0;
            end
        end
    end

    assign SBUS_ACKN_A           = ack_a_q;
    assign SBUS_ACKN_B           = ack_b_q;
    assign SBUS_DATA_VALID_A_OUT = dv_a_q;
    assign SBUS_DATA_VALID_B_OUT = dv_b_q;
    assign SBUS_D_OUT            = dout_q;
    assign SBUS_DATA_PAR_OUT     = dpar_q;
    assign SBUS_ERROR            = err_q;
    assign SBUS_ADR_PAR_ERR      = par_err_q;
    assign RAM_ADR               = ram_adr_q;
    assign RAM_WE                = ram_we_q;
    assign RAM_WDATA             = ram_wdata_q;

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// tb/tb_sbus_mem_ctl.sv - self-checking bench for sbus_mem_ctl with a per-cycle output model.
module tb_sbus_mem_ctl;
    localparam int AW   = 12;
    localparam int TMO  = 16;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          CROBAR_N, SBUS_MEM_RESET, SBUS_START_A, SBUS_START_B;
    logic [3:0]    SBUS_RQ;
    logic          SBUS_RD_RQ, SBUS_WR_RQ, SBUS_ADR_PAR, SBUS_DATA_PAR_IN;
    logic [AW-1:0] SBUS_ADR;
    logic [35:0]   SBUS_D_IN;
    logic          SBUS_DATA_VALID_A_IN, SBUS_DATA_VALID_B_IN;
    logic          SBUS_ACKN_A, SBUS_ACKN_B, SBUS_DATA_VALID_A_OUT, SBUS_DATA_VALID_B_OUT;
    logic [35:0]   SBUS_D_OUT;
    logic          SBUS_DATA_PAR_OUT, SBUS_ERROR, SBUS_ADR_PAR_ERR;
    logic [AW-1:0] RAM_ADR;
    logic          RAM_WE;
    logic [36:0]   RAM_WDATA, RAM_RDATA;

    always #5 clk = ~clk;

    sbus_mem_ctl #(.AW(AW), .WR_TIMEOUT(TMO)) dut (
        .CLK(clk), .CROBAR_N(CROBAR_N), .SBUS_MEM_RESET(SBUS_MEM_RESET),
        .SBUS_START_A(SBUS_START_A), .SBUS_START_B(SBUS_START_B), .SBUS_RQ(SBUS_RQ),
        .SBUS_RD_RQ(SBUS_RD_RQ), .SBUS_WR_RQ(SBUS_WR_RQ), .SBUS_ADR(SBUS_ADR),
        .SBUS_ADR_PAR(SBUS_ADR_PAR), .SBUS_D_IN(SBUS_D_IN), .SBUS_DATA_PAR_IN(SBUS_DATA_PAR_IN),
        .SBUS_DATA_VALID_A_IN(SBUS_DATA_VALID_A_IN), .SBUS_DATA_VALID_B_IN(SBUS_DATA_VALID_B_IN),
        .SBUS_ACKN_A(SBUS_ACKN_A), .SBUS_ACKN_B(SBUS_ACKN_B),
        .SBUS_DATA_VALID_A_OUT(SBUS_DATA_VALID_A_OUT), .SBUS_DATA_VALID_B_OUT(SBUS_DATA_VALID_B_OUT),
        .SBUS_D_OUT(SBUS_D_OUT), .SBUS_DATA_PAR_OUT(SBUS_DATA_PAR_OUT), .SBUS_ERROR(SBUS_ERROR),
        .SBUS_ADR_PAR_ERR(SBUS_ADR_PAR_ERR), .RAM_ADR(RAM_ADR), .RAM_WE(RAM_WE),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    // Backing RAM: synchronous read, one cycle of latency; preload port for setup.
    logic [36:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_adr;
    logic [36:0]   pre_dat;
    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (RAM_WE) mem[RAM_ADR] <= RAM_WDATA;
        RAM_RDATA <= mem[RAM_ADR];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected outputs per cycle and expected memory image.
    bit            exp_ack_a [0:MAXC-1];
    bit            exp_ack_b [0:MAXC-1];
    bit            exp_dv_a  [0:MAXC-1];
    bit            exp_dv_b  [0:MAXC-1];
    bit            exp_err   [0:MAXC-1];
    bit            exp_perr  [0:MAXC-1];
    logic [36:0]   exp_word  [0:MAXC-1];
    logic [36:0]   ref_mem   [0:(1<<AW)-1];
    logic [AW-1:0] wr_q [$];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [36:0] good(input logic [35:0] d);
        return {~^d, d};
    endfunction

    // c0: cycle in which START is high and gets accepted. Returns first IDLE cycle, or -1 for a write.
    function automatic int sched_req(input bit pb, input bit rd, input bit wr, input logic [3:0] rq,
                                     input logic [AW-1:0] adr, input bit par_ok, input int c0);
        int k = 0;
        logic [1:0] p;
        logic [AW-1:0] a;
        if (pb) exp_ack_b[c0+1] = 1'b1; else exp_ack_a[c0+1] = 1'b1;
        if (!par_ok) begin
            exp_perr[c0+1] = 1'b1;
            exp_err[c0+1]  = 1'b1;
            return c0 + 2;
        end
        if (rd == wr) begin
            exp_err[c0+1] = 1'b1;
            return c0 + 2;
        end
        if (rq == 4'd0) return c0 + 2;
        for (int i = 0; i < 4; i++) begin
            p = adr[1:0] + 2'(i);
            if (rq[p]) begin
                a = {adr[AW-1:2], p};
                if (wr) wr_q.push_back(a);
                else begin
                    if (pb) exp_dv_b[c0+3+k] = 1'b1; else exp_dv_a[c0+3+k] = 1'b1;
                    exp_word[c0+3+k] = ref_mem[a];
                    exp_err[c0+3+k]  = ~^ref_mem[a];
                end
                k++;
            end
        end
        return wr ? -1 : c0 + 3 + k;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outs", {58'd0, SBUS_ACKN_A, SBUS_ACKN_B, SBUS_DATA_VALID_A_OUT, SBUS_DATA_VALID_B_OUT,
                         SBUS_ERROR, SBUS_ADR_PAR_ERR},
                {58'd0, exp_ack_a[cyc], exp_ack_b[cyc], exp_dv_a[cyc], exp_dv_b[cyc],
                 exp_err[cyc], exp_perr[cyc]});
            if (exp_dv_a[cyc] || exp_dv_b[cyc])
                chk("rdata", {27'd0, SBUS_DATA_PAR_OUT, SBUS_D_OUT}, {27'd0, exp_word[cyc]});
        end
    end

    task automatic to_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [36:0] v);
        pre_we = 1'b1; pre_adr = a; pre_dat = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic drive_req(input bit pb, input bit rd, input bit wr, input logic [3:0] rq,
                             input logic [AW-1:0] adr, input bit par_ok);
        if (pb) SBUS_START_B = 1'b1; else SBUS_START_A = 1'b1;
        SBUS_RD_RQ = rd; SBUS_WR_RQ = wr; SBUS_RQ = rq; SBUS_ADR = adr;
        SBUS_ADR_PAR = par_ok ? ~^adr : ^adr;
    endtask

    task automatic strobe(input bit pb, input logic [35:0] d, input bit par_ok);
        int s = cyc;
        logic [AW-1:0] a;
        if (pb) SBUS_DATA_VALID_B_IN = 1'b1; else SBUS_DATA_VALID_A_IN = 1'b1;
        SBUS_D_IN = d;
        SBUS_DATA_PAR_IN = par_ok ? ~^d : ^d;
        if (!par_ok) exp_err[s+1] = 1'b1;
        a = wr_q.pop_front();
        ref_mem[a] = {SBUS_DATA_PAR_IN, d};
        to_cycle(s + 1);
        SBUS_DATA_VALID_A_IN = 1'b0;
        SBUS_DATA_VALID_B_IN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, idle, ib;
        CROBAR_N = 1'b0; SBUS_MEM_RESET = 1'b0; SBUS_START_A = 1'b0; SBUS_START_B = 1'b0;
        SBUS_RQ = 4'd0; SBUS_RD_RQ = 1'b0; SBUS_WR_RQ = 1'b0; SBUS_ADR = '0; SBUS_ADR_PAR = 1'b0;
        SBUS_D_IN = 36'd0; SBUS_DATA_PAR_IN = 1'b0;
        SBUS_DATA_VALID_A_IN = 1'b0; SBUS_DATA_VALID_B_IN = 1'b0;
        pre_we = 1'b0; pre_adr = '0; pre_dat = 37'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {57'd0, SBUS_ACKN_A, SBUS_ACKN_B, SBUS_DATA_VALID_A_OUT, SBUS_DATA_VALID_B_OUT,
                            SBUS_ERROR, SBUS_ADR_PAR_ERR, RAM_WE}, 64'd0);
        chk("rst_dout", {27'd0, SBUS_DATA_PAR_OUT, SBUS_D_OUT}, 64'd0);
        chk("rst_ram", {15'd0, RAM_ADR, RAM_WDATA}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            preload(12'h100 + 12'(i), good(36'hA5C3E1100 + 36'(i)));
            preload(12'h200 + 12'(i), good(36'hA5C3E1200 + 36'(i)));
        end
        preload(12'h300, {^36'hA5C3E1300, 36'hA5C3E1300});
        CROBAR_N = 1'b1;
        chk_en = 1'b1;
        to_cycle(cyc + 2);

        // Read quad starting mid-quad at 0x102.
        c = cyc;
        drive_req(0, 1, 0, 4'hF, 12'h102, 1);
        idle = sched_req(0, 1, 0, 4'hF, 12'h102, 1, c);
        to_cycle(c + 1); chk("rq_ack", {63'd0, SBUS_ACKN_A}, 64'd1);
        to_cycle(c + 2); SBUS_START_A = 1'b0;
        to_cycle(c + 3); chk("rq_w0", {28'd0, SBUS_D_OUT}, {28'd0, 36'hA5C3E1102});
        to_cycle(c + 6); chk("rq_w3", {27'd0, SBUS_DATA_VALID_A_OUT, SBUS_D_OUT}, {27'd1, 36'hA5C3E1101});
        to_cycle(idle + 2);

        // Partial write on port B; port-A strobe ignored; second word carries bad parity.
        c = cyc;
        drive_req(1, 0, 1, 4'b0101, 12'h200, 1);
        void'(sched_req(1, 0, 1, 4'b0101, 12'h200, 1, c));
        to_cycle(c + 2); SBUS_START_B = 1'b0;
        SBUS_DATA_VALID_A_IN = 1'b1; SBUS_D_IN = 36'o777; SBUS_DATA_PAR_IN = 1'b0;
        to_cycle(c + 3); SBUS_DATA_VALID_A_IN = 1'b0;
        strobe(1, 36'o123, 1);
        to_cycle(c + 5);
        strobe(1, 36'o456, 0);
        to_cycle(c + 9);
        chk("wr_200", {27'd0, mem[12'h200]}, {27'd0, 1'b1, 36'o123});
        chk("wr_202", {27'd0, mem[12'h202]}, {27'd0, 1'b1, 36'o456});
        chk("wr_201", {28'd0, mem[12'h201][35:0]}, {28'd0, 36'hA5C3E1201});
        for (int i = 0; i < 4; i++)
            chk("wr_model", {27'd0, mem[12'h200 + 12'(i)]}, {27'd0, ref_mem[12'h200 + 12'(i)]});

        // Request-check boundaries: bad address parity, RD==WR, empty mask.
        c = cyc;
        drive_req(0, 1, 0, 4'hF, 12'h104, 0);
        idle = sched_req(0, 1, 0, 4'hF, 12'h104, 0, c);
        to_cycle(c + 1);
        chk("perr", {61'd0, SBUS_ACKN_A, SBUS_ERROR, SBUS_ADR_PAR_ERR}, 64'd7);
        to_cycle(c + 2); SBUS_START_A = 1'b0;
        to_cycle(idle + 2);
        c = cyc;
        drive_req(1, 1, 1, 4'hF, 12'h108, 1);
        idle = sched_req(1, 1, 1, 4'hF, 12'h108, 1, c);
        to_cycle(c + 1);
        chk("rdwr", {61'd0, SBUS_ACKN_B, SBUS_ERROR, SBUS_ADR_PAR_ERR}, 64'd6);
        to_cycle(c + 2); SBUS_START_B = 1'b0;
        to_cycle(idle + 2);
        c = cyc;
        drive_req(0, 1, 0, 4'h0, 12'h100, 1);
        idle = sched_req(0, 1, 0, 4'h0, 12'h100, 1, c);
        to_cycle(c + 2); SBUS_START_A = 1'b0;
        to_cycle(idle + 2);

        // Simultaneous starts: A first, B from the following IDLE, A held high throughout.
        c = cyc;
        drive_req(0, 1, 0, 4'b0001, 12'h100, 1);
        SBUS_START_B = 1'b1;
        idle = sched_req(0, 1, 0, 4'b0001, 12'h100, 1, c);
        ib = sched_req(1, 1, 0, 4'b0001, 12'h100, 1, idle);
        to_cycle(c + 5); chk("arb_ackb", {62'd0, SBUS_ACKN_A, SBUS_ACKN_B}, 64'd1);
        to_cycle(c + 6); SBUS_START_A = 1'b0; SBUS_START_B = 1'b0;
        to_cycle(ib + 2);

        // Corrupt stored parity: word delivered with ERROR alongside.
        c = cyc;
        drive_req(1, 1, 0, 4'b0001, 12'h300, 1);
        idle = sched_req(1, 1, 0, 4'b0001, 12'h300, 1, c);
        to_cycle(c + 2); SBUS_START_B = 1'b0;
        to_cycle(c + 3);
        chk("bad_par_rd", {26'd0, SBUS_DATA_VALID_B_OUT, SBUS_ERROR, SBUS_D_OUT}, {26'd0, 2'b11, 36'hA5C3E1300});
        to_cycle(idle + 2);

        // SBUS_MEM_RESET at cycle 4 of a 4-word read; held STARTs must not be re-accepted.
        c = cyc;
        drive_req(0, 1, 0, 4'hF, 12'h100, 1);
        void'(sched_req(0, 1, 0, 4'hF, 12'h100, 1, c));
        for (int t = c + 5; t < c + 10; t++) begin
            exp_dv_a[t] = 1'b0;
            exp_err[t] = 1'b0;
        end
        to_cycle(c + 4); SBUS_MEM_RESET = 1'b1;
        to_cycle(c + 5); SBUS_MEM_RESET = 1'b0; SBUS_START_B = 1'b1;
        to_cycle(c + 6); chk("mrst_hold", {28'd0, SBUS_D_OUT}, {28'd0, 36'hA5C3E1101});
        to_cycle(c + 10); SBUS_START_A = 1'b0; SBUS_START_B = 1'b0;
        to_cycle(c + 11);
        drive_req(0, 1, 0, 4'b0010, 12'h100, 1);
        idle = sched_req(0, 1, 0, 4'b0010, 12'h100, 1, c + 11);
        to_cycle(c + 12); chk("mrst_reacc", {63'd0, SBUS_ACKN_A}, 64'd1);
        to_cycle(c + 13); SBUS_START_A = 1'b0;
        to_cycle(idle + 2);

`ifdef SBUS_MEM_WR_TIMEOUT_EN
        c = cyc;
        drive_req(0, 0, 1, 4'hF, 12'h200, 1);
        void'(sched_req(0, 0, 1, 4'hF, 12'h200, 1, c));
        wr_q.delete();
        exp_err[c + 1 + TMO] = 1'b1;
        to_cycle(c + 2); SBUS_START_A = 1'b0;
        to_cycle(c + 1 + TMO); chk("wr_tmo", {63'd0, SBUS_ERROR}, 64'd1);
        to_cycle(c + TMO + 4);
`endif

        to_cycle(cyc + 3);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
